spi_adc_reader: RTL and testbench

Parametrised multi-channel serial ADC front end. It is the successor to the single-channel 12-bit SPI ADC reader. It drives one shared SCK/CS_N pair and captures CHANNELS parallel SDO lines, one per ADC. It extracts a configurable data field from each frame and presents the words on a valid/ready interface to the downstream DSP path. It supports single-shot and continuous sampling, with an enforced CS-high conversion gap and a sticky overrun flag.

---
 rtl/spi_adc_reader.sv | 145 ++++++++++++++
 tb/tb_spi_adc_reader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_reader.sv
// Multi-channel SPI ADC front end: shared SCK/CS_N, per-channel SDO capture,
// field extraction and a valid/ready result register with sticky overrun.
module spi_adc_reader #(
  parameter int HBDIV      = 1,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int LEAD_BITS  = 2,
  parameter int CHANNELS   = 2,
  parameter int GAP_CLKS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          cont_en,
  output logic                          busy,
  output logic                          sck,
  output logic                          cs_n,
  input  logic [CHANNELS-1:0]           sdo,
  output logic [CHANNELS*DATA_BITS-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun,
  input  logic                          clr_ovr
);

  localparam int HW = $clog2(2*FRAME_BITS+1);
  localparam int DW = (HBDIV > 1) ? $clog2(HBDIV) : 1;
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [HW-1:0] H_LAST   = HW'(2*FRAME_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(HBDIV-1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS-1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;

  state_t                        r_state;
  logic [DW-1:0]                 r_div;
  logic [HW-1:0]                 r_h;
  logic [GW-1:0]                 r_gap;
  logic [FRAME_BITS-1:0]         r_shift [CHANNELS];
  logic                          r_busy;
  logic                          r_sck;
  logic                          r_cs_n;
  logic [CHANNELS*DATA_BITS-1:0] r_out_data;
  logic                          r_out_valid;
  logic                          r_overrun;

  logic                          w_tick;
  logic                          w_load;
  logic                          w_ovr_set;
  logic [CHANNELS*DATA_BITS-1:0] w_sample;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_load    = (r_state == S_FRAME) && w_tick && (r_h == H_LAST);
  assign w_ovr_set = w_load && r_out_valid && !out_ready;

  always_comb begin
    w_sample = '0;
    for (int unsigned c = 0; c < CHANNELS; c++)
      w_sample[c*DATA_BITS +: DATA_BITS] = r_shift[c][FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_h         <= '0;
      r_gap       <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) r_shift[c] <= '0;
      r_busy      <= 1'b0;
      r_sck       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // a set event on the same edge as clr_ovr must win
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (clr_ovr) r_overrun <= 1'b0;

      if (w_load) begin
        r_out_data  <= w_sample;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start || cont_en) begin
            r_state <= S_FRAME;
            r_busy  <= 1'b1;
            r_cs_n  <= 1'b0;
            r_sck   <= 1'b0;
            r_div   <= '0;
            r_h     <= '0;
          end
        end
        S_FRAME: begin
          r_div <= w_tick ? '0 : r_div + 1'b1;
          if (w_tick) begin
            if (r_h == H_LAST) begin
              r_state <= S_GAP;
              r_cs_n  <= 1'b1;
              r_sck   <= 1'b0;
              r_gap   <= '0;
            end else begin
              r_h   <= r_h + 1'b1;
              r_sck <= ~r_h[0];
            end
            // end of an sck-high phase: capture one bit per channel, MSB first
            if (r_h[0]) begin
              for (int unsigned c = 0; c < CHANNELS; c++)
                r_shift[c] <= {r_shift[c][FRAME_BITS-2:0], sdo[c]};
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            if (cont_en) begin
              r_state <= S_FRAME;
              r_cs_n  <= 1'b0;
              r_sck   <= 1'b0;
              r_div   <= '0;
              r_h     <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign sck       = r_sck;
  assign cs_n      = r_cs_n;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_spi_adc_reader.sv
// Scoreboard bench for spi_adc_reader: a behavioural ADC feeds frames, expected
// samples are queued with each frame and compared when the DUT presents them.
module tb_spi_adc_reader;

  localparam int HB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cont_en, out_ready, clr_ovr;
  logic        busy, sck, cs_n, out_valid, overrun;
  logic [1:0]  sdo;
  logic [23:0] out_data;

  logic        start_b, cont_b, ready_b, clr_b;
  logic        busy_b, sck_b, cs_n_b, out_valid_b, overrun_b;
  logic        sdo_b;
  logic [13:0] out_data_b;

  int total = 0;
  int bad   = 0;

  logic [15:0] adc0_q[$], adc1_q[$];
  logic [23:0] exp_q[$];
  logic [15:0] cur0 = '0, cur1 = '0;
  int          idx = 15;
  logic        prev_sck = 1'b0, prev_cs = 1'b1;

  always #5 clk = ~clk;

  spi_adc_reader #(.HBDIV(HB), .FRAME_BITS(16), .DATA_BITS(12), .LEAD_BITS(2),
                   .CHANNELS(2), .GAP_CLKS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cont_en(cont_en), .busy(busy),
    .sck(sck), .cs_n(cs_n), .sdo(sdo), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .clr_ovr(clr_ovr));

  spi_adc_reader #(.HBDIV(1), .FRAME_BITS(14), .DATA_BITS(14), .LEAD_BITS(0),
                   .CHANNELS(1), .GAP_CLKS(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cont_en(cont_b), .busy(busy_b),
    .sck(sck_b), .cs_n(cs_n_b), .sdo(sdo_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(ready_b), .overrun(overrun_b), .clr_ovr(clr_b));

  // ADC for the single-channel instance: all-ones frame whenever selected
  assign sdo_b = ~cs_n_b;

  // ADC model: loads a frame on CS_N fall, presents MSB, advances after each SCK fall
  always @(negedge clk) begin
    if (cs_n) idx = 15;
    else if (prev_cs) begin
      cur0 = (adc0_q.size() > 0) ? adc0_q.pop_front() : 16'h0000;
      cur1 = (adc1_q.size() > 0) ? adc1_q.pop_front() : 16'h0000;
    end else if (prev_sck && !sck && idx > 0) idx--;
    prev_sck = sck;
    prev_cs  = cs_n;
    sdo = {cur1[idx[3:0]], cur0[idx[3:0]]};
  end

  task automatic push_frame(input logic [15:0] f0, input logic [15:0] f1);
    adc0_q.push_back(f0);
    adc1_q.push_back(f1);
    exp_q.push_back({f1[13:2], f0[13:2]});
  endtask

  task automatic measure_frame(output int low, output int pulses, output int badw,
                               output bit ended);
    int run;
    low = 0; pulses = 0; badw = 0; run = 0; ended = 0;
    for (int i = 0; i < 300; i++) begin
      if (cs_n) begin ended = 1; break; end
      low++;
      if (sck) run++;
      else if (run != 0) begin
        pulses++;
        if (run != HB) badw++;
        run = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle(input int lim, output int cnt);
    cnt = 0;
    while (busy && cnt < lim) begin cnt++; @(negedge clk); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; cont_en = 0; out_ready = 0; clr_ovr = 0;
    start_b = 0; cont_b = 0; ready_b = 0; clr_b = 0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", sck); end
    total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (out_data !== 24'h0) begin bad++; $display("FAIL reset_data got=%h want=000000", out_data); end
    total++; if ({busy_b, sck_b, cs_n_b, out_valid_b, overrun_b} !== 5'b00100)
      begin bad++; $display("FAIL reset_b_ctl got=%b want=00100", {busy_b, sck_b, cs_n_b, out_valid_b, overrun_b}); end
    total++; if (out_data_b !== 14'h0) begin bad++; $display("FAIL reset_b_data got=%h want=0000", out_data_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int low, pulses, badw, bcnt;
    bit ended;
    logic [23:0] e, held;
    push_frame(16'h2AF0, 16'h048C);
    out_ready = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    measure_frame(low, pulses, badw, ended);
    total++; if (!ended) begin bad++; $display("FAIL single_timeout cs_n never rose"); end
    total++; if (low != 66) begin bad++; $display("FAIL single_cs_low got=%0d want=66", low); end
    total++; if (pulses != 16) begin bad++; $display("FAIL single_pulses got=%0d want=16", pulses); end
    total++; if (badw != 0) begin bad++; $display("FAIL single_sck_width got=%0d bad widths want=0", badw); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid_rise got=%b want=1", out_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    total++; if (out_data !== e) begin bad++; $display("FAIL single_data got=%h want=%h", out_data, e); end
    held = out_data;
    wait_idle(50, bcnt);
    total++; if (bcnt != 4) begin bad++; $display("FAIL single_busy_tail got=%0d want=4", bcnt); end
    total++; if (out_valid !== 1'b1 || out_data !== held)
      begin bad++; $display("FAIL single_hold got=%b/%h want=1/%h", out_valid, out_data, held); end
    out_ready = 1;
    @(negedge clk) out_ready = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_ack got=%b want=0", out_valid); end
  endtask

  task automatic test_cont();
    bit ok;
    int g, cnt;
    logic [23:0] e;
    push_frame(16'h0004, 16'h0000);
    push_frame(16'h0008, 16'h0000);
    push_frame(16'h000C, 16'h0000);
    out_ready = 1;
    cont_en = 1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(300, ok);
      total++; if (!ok) begin bad++; $display("FAIL cont_timeout frame=%0d", k); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      total++; if (out_data !== e) begin bad++; $display("FAIL cont_data frame=%0d got=%h want=%h", k, out_data, e); end
      if (k == 2) cont_en = 0;
      else begin
        g = 0;
        while (cs_n && g < 20) begin g++; @(negedge clk); end
        total++; if (g != 4) begin bad++; $display("FAIL cont_gap frame=%0d got=%0d want=4", k, g); end
      end
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL cont_overrun got=%b want=0", overrun); end
    wait_idle(50, cnt);
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0 || cs_n !== 1'b1)
      begin bad++; $display("FAIL cont_stop got busy=%b cs_n=%b want 0/1", busy, cs_n); end
    out_ready = 0;
  endtask

  task automatic test_overrun();
    int rises, cnt;
    logic pcs;
    logic [23:0] e;
    out_ready = 0;
    push_frame(16'h0010, 16'h1000);
    push_frame(16'h0020, 16'h2000);
    push_frame(16'h0030, 16'h3000);
    cont_en = 1;
    rises = 0;
    pcs = cs_n;
    for (int i = 0; i < 1000 && rises < 3; i++) begin
      @(negedge clk);
      if (!pcs && cs_n) begin
        rises++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid frame=%0d got=%b want=1", rises, out_valid); end
        total++; if (overrun !== (rises >= 2))
          begin bad++; $display("FAIL ovr_flag frame=%0d got=%b want=%b", rises, overrun, rises >= 2); end
        if (rises == 3) begin
          cont_en = 0;
          total++; if (out_data !== e) begin bad++; $display("FAIL ovr_data got=%h want=%h", out_data, e); end
        end
      end
      pcs = cs_n;
    end
    total++; if (rises != 3) begin bad++; $display("FAIL ovr_timeout got=%0d frames want=3", rises); end
    wait_idle(50, cnt);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
    clr_ovr = 1;
    @(negedge clk) clr_ovr = 0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid_kept got=%b want=1", out_valid); end
    out_ready = 1;
    @(negedge clk) out_ready = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_ack got=%b want=0", out_valid); end
  endtask

  task automatic test_busy_ignore();
    int low, pulses;
    logic psck;
    logic [23:0] e;
    push_frame(16'h5554, 16'h2AA8);
    out_ready = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    low = 0; pulses = 0; psck = 0;
    // i=0 is the first clk of the frame, so h=10 begins at i=20
    for (int i = 0; i < 200; i++) begin
      start = (i >= 20 && i < 23);
      if (!cs_n) low++;
      if (sck && !psck) pulses++;
      psck = sck;
      @(negedge clk);
    end
    start = 0;
    total++; if (low != 66) begin bad++; $display("FAIL ignore_cs_low got=%0d want=66", low); end
    total++; if (pulses != 16) begin bad++; $display("FAIL ignore_pulses got=%0d want=16", pulses); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    total++; if (out_valid !== 1'b1 || out_data !== e)
      begin bad++; $display("FAIL ignore_data got=%b/%h want=1/%h", out_valid, out_data, e); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ignore_overrun got=%b want=0", overrun); end
    out_ready = 1;
    @(negedge clk) out_ready = 0;
  endtask

  task automatic test_reset_mid();
    int low, pulses, badw, cnt;
    bit ended;
    logic [23:0] e;
    adc0_q.push_back(16'hFFFF);
    adc1_q.push_back(16'hFFFF);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (34) @(negedge clk);
    total++; if (sck !== 1'b1) begin bad++; $display("FAIL rstmid_pre_sck got=%b want=1", sck); end
    #2 rst = 1;
    #1;
    total++; if (cs_n !== 1'b1 || sck !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL rstmid_async got cs_n=%b sck=%b busy=%b want 1/0/0", cs_n, sck, busy); end
    @(negedge clk);
    total++; if ({cs_n, sck, busy, out_valid} !== 4'b1000)
      begin bad++; $display("FAIL rstmid_state got=%b want=1000", {cs_n, sck, busy, out_valid}); end
    rst = 0;
    @(negedge clk);
    push_frame(16'h3FFC, 16'h0000);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    measure_frame(low, pulses, badw, ended);
    total++; if (!ended || low != 66 || pulses != 16)
      begin bad++; $display("FAIL rstmid_frame got low=%0d pulses=%0d want 66/16", low, pulses); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
    total++; if (out_valid !== 1'b1 || out_data !== e)
      begin bad++; $display("FAIL rstmid_data got=%b/%h want=1/%h", out_valid, out_data, e); end
    wait_idle(50, cnt);
    out_ready = 1;
    @(negedge clk) out_ready = 0;
  endtask

  task automatic test_hb1();
    int low;
    bit ended;
    ready_b = 0;
    @(negedge clk) start_b = 1;
    @(negedge clk) start_b = 0;
    low = 0; ended = 0;
    for (int i = 0; i < 100; i++) begin
      if (cs_n_b) begin ended = 1; break; end
      low++;
      @(negedge clk);
    end
    total++; if (!ended || low != 29) begin bad++; $display("FAIL hb1_cs_low got=%0d want=29", low); end
    total++; if (out_valid_b !== 1'b1 || out_data_b !== 14'h3FFF)
      begin bad++; $display("FAIL hb1_data got=%b/%h want=1/3fff", out_valid_b, out_data_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cont();
    test_overrun();
    test_busy_ignore();
    test_reset_mid();
    test_hb1();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
